fir_sched: RTL

FIR_SCHED -- requirements
Module: fir_sched

---
 rtl/fir_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sched.sv
// fir_sched: feeds a polyphase FIR one input sample at a time and buffers
// its PHASES results for a DAC that drains them at its own rate.
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   in_sample/in_valid/in_ready : input sample stream into a small FIFO
//   fir_sample, fir_sample_ready : sample and one-cycle start strobe to the FIR
//   fir_out, fir_rdy  : FIR results, one per fir_rdy pulse
//   dac_tick          : output-rate strobe; each tick pops one result
//   dac_data, dac_valid : current DAC sample, dac_valid pulses on update
//   underrun, fault   : sticky flags (tick on empty FIFO, collect watchdog)
//   busy              : scheduler is not idle
//
// Sample data is moved bit-exact; no arithmetic touches it.
module fir_sched #(
   parameter int PHASES    = 8,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_sample,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] fir_sample,
   output logic        fir_sample_ready,
   input  logic [15:0] fir_out,
   input  logic        fir_rdy,
   input  logic        dac_tick,
   output logic [15:0] dac_data,
   output logic        dac_valid,
   output logic        underrun,
   output logic        fault,
   output logic        busy
);

   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int PH_W   = $clog2(PHASES + 1);
   localparam int WD_W   = $clog2(TIMEOUT + 1);

   localparam logic [IN_AW:0]  IN_FULL   = (IN_AW + 1)'(IN_DEPTH);
   // Highest occupancy that still leaves room for a full burst of results.
   localparam logic [OUT_AW:0] OUT_LIMIT = (OUT_AW + 1)'(OUT_DEPTH - PHASES);
   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PHASES - 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP, COLLECT} state_t;
   state_t state;

   logic signed [15:0] in_mem [IN_DEPTH];
   logic [IN_AW-1:0]   in_wr_ptr;
   logic [IN_AW-1:0]   in_rd_ptr;
   logic [IN_AW:0]     in_cnt;
   logic               in_push;
   logic               in_pop;

   logic signed [15:0] out_mem [OUT_DEPTH];
   logic [OUT_AW-1:0]  out_wr_ptr;
   logic [OUT_AW-1:0]  out_rd_ptr;
   logic [OUT_AW:0]    out_cnt;
   logic               out_push;
   logic               out_pop;
   logic [OUT_AW:0]    out_occ_eff;
   logic               issue_go;

   logic [PH_W-1:0]    phase_cnt;
   logic [WD_W-1:0]    wd_cnt;

   assign in_ready = (in_cnt != IN_FULL);
   assign in_push  = in_valid && in_ready;
   assign in_pop   = (state == ISSUE);

   assign out_push = (state == COLLECT) && fir_rdy;
   assign out_pop  = dac_tick && (out_cnt != '0);

   // A DAC pop on the same edge frees a slot, so it counts toward the room
   // needed to start the next burst.
   assign out_occ_eff = out_cnt - (OUT_AW + 1)'(out_pop);
   assign issue_go    = (in_cnt != '0) && (out_occ_eff <= OUT_LIMIT);

   // ---- FIFO storage (data only, never reset) ----
   always_ff @(posedge clk) begin
      if (in_push) in_mem[in_wr_ptr] <= in_sample;
      if (out_push) out_mem[out_wr_ptr] <= fir_out;
   end

   // ---- FIFO pointers and occupancy ----
   always_ff @(posedge clk) begin
      if (rst) begin
         in_wr_ptr  <= '0;
         in_rd_ptr  <= '0;
         in_cnt     <= '0;
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_cnt    <= '0;
      end else begin
         if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
         if (in_pop) in_rd_ptr <= in_rd_ptr + IN_AW'(1);
         case ({in_push, in_pop})
            2'b10:   in_cnt <= in_cnt + (IN_AW + 1)'(1);
            2'b01:   in_cnt <= in_cnt - (IN_AW + 1)'(1);
            default: ;
         endcase

         if (out_push) out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
         if (out_pop) out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
         case ({out_push, out_pop})
            2'b10:   out_cnt <= out_cnt + (OUT_AW + 1)'(1);
            2'b01:   out_cnt <= out_cnt - (OUT_AW + 1)'(1);
            default: ;
         endcase
      end
   end

   // ---- Scheduler FSM with registered FIR-side outputs ----
   // The strobe is raised on the edge into ISSUE together with the sample,
   // so the FIR sees both during the ISSUE cycle; the FIFO head is retired
   // on the edge leaving ISSUE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         phase_cnt        <= '0;
         wd_cnt           <= '0;
         fir_sample       <= '0;
         fir_sample_ready <= 1'b0;
         fault            <= 1'b0;
         busy             <= 1'b0;
      end else begin
         fir_sample_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (issue_go) begin
                  state            <= ISSUE;
                  fir_sample       <= in_mem[in_rd_ptr];
                  fir_sample_ready <= 1'b1;
                  busy             <= 1'b1;
               end
            end
            ISSUE: begin
               state <= GAP;
            end
            GAP: begin
               phase_cnt <= '0;
               wd_cnt    <= '0;
               state     <= COLLECT;
            end
            COLLECT: begin
               if (fir_rdy) begin
                  phase_cnt <= phase_cnt + PH_W'(1);
                  if (phase_cnt == PH_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  // Watchdog accumulates every quiet cycle of the burst,
                  // not just consecutive ones.
                  wd_cnt <= wd_cnt + WD_W'(1);
                  if (wd_cnt == WD_LAST) begin
                     fault <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---- DAC output register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         dac_data  <= '0;
         dac_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         dac_valid <= out_pop;
         if (out_pop) dac_data <= out_mem[out_rd_ptr];
         if (dac_tick && (out_cnt == '0)) underrun <= 1'b1;
      end
   end

endmodule
